// File: rtl/quantum_scheduler.sv
// quantum_scheduler: round-robin time-slice scheduler feeding the CPU PC mux.
// Counts retired instructions per slice, saves the interrupted PC on a
// switch, then scans the process table one index per cycle for the next
// runnable process.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; outputs quiet
// RUN      | current process executing, retires counted against quantum
// SAVE     | write latched pc+1 into the current process' table entry
// SELECT   | examine one table index per cycle for the next active one
// DISPATCH | switch_req pulse with next_pc of the selected process
// DONE     | all_done pulse, no active process remains
module quantum_scheduler #(
    parameter int NPROC     = 10,
    parameter int PROC_SIZE = 300,
    parameter int QUANTUM   = 8,
    parameter int QW        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  num_procs,
    input  logic        retire,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        io_instr,
    input  logic        proc_end,
    output logic        switch_req,
    output logic [31:0] next_pc,
    output logic [3:0]  cur_proc,
    output logic        busy,
    output logic        all_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_DISPATCH,
        S_DONE
    } state_t;

    localparam logic [3:0]    NPROC_W = 4'(NPROC);
    localparam logic [QW-1:0] QLAST   = QW'(QUANTUM - 1);

    state_t          state_q, state_d;
    logic [3:0]      n_q, n_d;
    logic [3:0]      scan_q, scan_d;
    logic [3:0]      scan_cnt_q, scan_cnt_d;
    logic [QW-1:0]   cnt_q, cnt_d;
    logic [31:0]     latch_q, latch_d;
    logic [NPROC:0]  active_q, active_d;
    logic [31:0]     saved_q [0:NPROC];
    logic [31:0]     saved_d [0:NPROC];
    logic            switch_req_q, switch_req_d;
    logic [31:0]     next_pc_q, next_pc_d;
    logic [3:0]      cur_proc_q, cur_proc_d;
    logic            busy_q, busy_d;
    logic            all_done_q, all_done_d;

    logic [3:0]      n_start;
    logic [3:0]      cand;
    logic            fire;

    // Clamped process count, next scan candidate (wraps n -> 1), valid retire.
    assign n_start = (num_procs > NPROC_W) ? NPROC_W : num_procs;
    assign cand    = (scan_q >= n_q) ? 4'd1 : scan_q + 4'd1;
    assign fire    = retire & ~stall;

    // Next-state, table updates and registered-output values.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        scan_d       = scan_q;
        scan_cnt_d   = scan_cnt_q;
        cnt_d        = cnt_q;
        latch_d      = latch_q;
        active_d     = active_q;
        saved_d      = saved_q;
        switch_req_d = 1'b0;
        all_done_d   = 1'b0;
        next_pc_d    = next_pc_q;
        cur_proc_d   = cur_proc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d = n_start;
                    for (int i = 1; i <= NPROC; i++) begin
                        active_d[4'(i)] = (i <= int'(n_start));
                        if (i <= int'(n_start)) begin
                            saved_d[4'(i)] = 32'(i) * 32'(PROC_SIZE);
                        end
                    end
                    // Scan starts at n so the first candidate wraps to index 1.
                    scan_d     = n_start;
                    scan_cnt_d = 4'd0;
                    if (n_start == 4'd0) begin
                        state_d    = S_DONE;
                        all_done_d = 1'b1;
                        cur_proc_d = 4'd0;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end

            S_RUN: begin
                if (fire) begin
                    if (proc_end) begin
                        active_d[cur_proc_q] = 1'b0;
                        scan_d               = cur_proc_q;
                        scan_cnt_d           = 4'd0;
                        state_d              = S_SELECT;
                    end else if (io_instr || (cnt_q == QLAST)) begin
                        latch_d = pc + 32'd1;
                        state_d = S_SAVE;
                    end else begin
                        cnt_d = cnt_q + QW'(1);
                    end
                end
            end

            S_SAVE: begin
                saved_d[cur_proc_q] = latch_q;
                scan_d              = cur_proc_q;
                scan_cnt_d          = 4'd0;
                state_d             = S_SELECT;
            end

            S_SELECT: begin
                if (active_q[cand]) begin
                    state_d      = S_DISPATCH;
                    switch_req_d = 1'b1;
                    next_pc_d    = saved_q[cand];
                    cur_proc_d   = cand;
                    cnt_d        = '0;
                end else begin
                    scan_d     = cand;
                    scan_cnt_d = scan_cnt_q + 4'd1;
                    // The current process is examined last, so n misses means none left.
                    if ((scan_cnt_q + 4'd1) == n_q) begin
                        state_d    = S_DONE;
                        all_done_d = 1'b1;
                        cur_proc_d = 4'd0;
                    end
                end
            end

            S_DISPATCH: state_d = S_RUN;

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Process table, slice counter, scan pointer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q          <= 4'd0;
            scan_q       <= 4'd0;
            scan_cnt_q   <= 4'd0;
            cnt_q        <= '0;
            latch_q      <= 32'd0;
            active_q     <= '0;
            for (int i = 0; i <= NPROC; i++) begin
                saved_q[i] <= 32'd0;
            end
            switch_req_q <= 1'b0;
            next_pc_q    <= 32'd0;
            cur_proc_q   <= 4'd0;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            n_q          <= n_d;
            scan_q       <= scan_d;
            scan_cnt_q   <= scan_cnt_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            active_q     <= active_d;
            saved_q      <= saved_d;
            switch_req_q <= switch_req_d;
            next_pc_q    <= next_pc_d;
            cur_proc_q   <= cur_proc_d;
            busy_q       <= busy_d;
            all_done_q   <= all_done_d;
        end
    end

    assign switch_req = switch_req_q;
    assign next_pc    = next_pc_q;
    assign cur_proc   = cur_proc_q;
    assign busy       = busy_q;
    assign all_done   = all_done_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// tb_quantum_scheduler: randomized CPU-side stimulus against a round-robin
// reference model kept as plain arrays (active flags, saved PCs, current).
module tb_quantum_scheduler;

    localparam int NPROC     = 10;
    localparam int PROC_SIZE = 300;
    localparam int QUANTUM   = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  num_procs;
    logic        retire;
    logic        stall;
    logic [31:0] pc;
    logic        io_instr;
    logic        proc_end;
    logic        switch_req;
    logic [31:0] next_pc;
    logic [3:0]  cur_proc;
    logic        busy;
    logic        all_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int          m_n;
    int          m_cur;
    bit          m_act   [1:15];
    logic [31:0] m_saved [1:15];
    bit          m_running;
    logic [31:0] pc_run;

    quantum_scheduler #(
        .NPROC     (NPROC),
        .PROC_SIZE (PROC_SIZE),
        .QUANTUM   (QUANTUM),
        .QW        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_procs  (num_procs),
        .retire     (retire),
        .stall      (stall),
        .pc         (pc),
        .io_instr   (io_instr),
        .proc_end   (proc_end),
        .switch_req (switch_req),
        .next_pc    (next_pc),
        .cur_proc   (cur_proc),
        .busy       (busy),
        .all_done   (all_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Round robin from the current process, current one examined last.
    function automatic int pick(output int k);
        k = m_n;
        for (int j = 1; j <= m_n; j++) begin
            int idx;
            idx = ((m_cur + j - 1) % m_n) + 1;
            if (m_act[idx]) begin
                k = j;
                return idx;
            end
        end
        return 0;
    endfunction

    task automatic drive_garbage();
        start    = 1'b0;
        retire   = 1'($urandom_range(0, 1));
        stall    = 1'($urandom_range(0, 1));
        io_instr = 1'($urandom_range(0, 1));
        proc_end = 1'($urandom_range(0, 1));
        pc       = $urandom;
    endtask

    // Wait for the dispatch (sel != 0) or all_done (sel == 0) expected lat cycles later.
    task automatic wait_event(input int lat, input int sel);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (switch_req || all_done) begin
                chk("event_latency", c, lat);
                drive_garbage();
                if (sel != 0) begin
                    chk("event_is_switch", 32'(switch_req), 1);
                    chk("next_pc", next_pc, m_saved[sel]);
                    chk("cur_proc_dispatch", 32'(cur_proc), sel);
                    chk("busy_dispatch", 32'(busy), 1);
                    m_cur = sel;
                end else begin
                    chk("event_is_done", 32'(all_done), 1);
                    chk("switch_on_done", 32'(switch_req), 0);
                    chk("cur_proc_done", 32'(cur_proc), 0);
                    chk("busy_done", 32'(busy), 1);
                    m_running = 1'b0;
                    @(negedge clk);
                    chk("busy_idle", 32'(busy), 0);
                    chk("done_pulse", 32'(all_done), 0);
                    drive_garbage();
                end
                return;
            end
            chk("busy_wait", 32'(busy), 1);
            drive_garbage();
            start = ($urandom_range(0, 3) == 0);
        end
        chk("event_timeout", 32'(switch_req | all_done), 1);
        finish_tb();
    endtask

    task automatic do_start(input int num);
        int k;
        int sel;
        m_n = (num > NPROC) ? NPROC : num;
        for (int i = 1; i <= 15; i++) m_act[i] = (i <= m_n);
        for (int i = 1; i <= m_n; i++) m_saved[i] = 32'(i * PROC_SIZE);
        m_cur     = m_n;
        m_running = 1'b1;
        drive_garbage();
        start     = 1'b1;
        num_procs = 4'(num);
        sel = pick(k);
        wait_event(1 + k, sel);
    endtask

    // mode: 0 random, 1 full quantum, 2 io on 3rd retire, 3 proc_end+io, 4 20 stalls then quantum
    task automatic run_slice(input int mode);
        int r = 0;
        int stalls = 0;
        int k, sel, lat;
        bit ret, stl, io, pe, ev;
        pc_run = m_saved[m_cur];
        if (mode == 0 && $urandom_range(0, 5) == 0) pc_run = 32'hFFFF_FFF8 + $urandom_range(0, 7);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("switch_in_run", 32'(switch_req), 0);
            chk("done_in_run", 32'(all_done), 0);
            chk("cur_proc_run", 32'(cur_proc), m_cur);
            chk("busy_run", 32'(busy), 1);
            drive_garbage();
            start = ($urandom_range(0, 7) == 0);
            case (mode)
                1: begin ret = 1; stl = 0; io = 0; pe = 0; end
                2: begin ret = 1; stl = 0; io = (r == 2); pe = 0; end
                3: begin ret = 1; stl = 0; io = 1; pe = 1; end
                4: begin
                    ret = 1;
                    stl = (stalls < 20);
                    io  = 1'($urandom_range(0, 1));
                    pe  = 1'($urandom_range(0, 1));
                    if (stl) stalls++;
                    else begin io = 0; pe = 0; end
                end
                default: begin
                    ret = 1'($urandom_range(0, 1));
                    stl = ($urandom_range(0, 3) == 0);
                    io  = ($urandom_range(0, 15) == 0);
                    pe  = ($urandom_range(0, 11) == 0);
                end
            endcase
            retire   = ret;
            stall    = stl;
            io_instr = io;
            proc_end = pe;
            if (ret && !stl) begin
                pc = pc_run;
                r++;
                ev = 1;
                if (pe) begin
                    m_act[m_cur] = 1'b0;
                    sel = pick(k);
                    lat = 1 + k;
                end else if (io || r == QUANTUM) begin
                    m_saved[m_cur] = pc_run + 32'd1;
                    sel = pick(k);
                    lat = 2 + k;
                end else begin
                    ev = 0;
                end
                pc_run = pc_run + 32'd1;
                if (ev) begin
                    wait_event(lat, sel);
                    return;
                end
            end
        end
        chk("slice_budget", r, QUANTUM);
        finish_tb();
    endtask

    initial begin
        int slices;
        reset     = 1'b1;
        start     = 1'b0;
        num_procs = 4'd0;
        retire    = 1'b0;
        stall     = 1'b0;
        pc        = 32'd0;
        io_instr  = 1'b0;
        proc_end  = 1'b0;
        m_n       = 0;
        m_cur     = 0;
        m_running = 1'b0;
        pc_run    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_switch_req", 32'(switch_req), 0);
        chk("rst_next_pc", next_pc, 0);
        chk("rst_cur_proc", 32'(cur_proc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_all_done", 32'(all_done), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed walk: three processes, quantum expiry, io switch, proc_end beats io.
        do_start(3);
        run_slice(1);
        run_slice(2);
        run_slice(1);
        run_slice(1);
        run_slice(1);
        run_slice(3);
        slices = 0;
        while (m_running) begin
            run_slice((slices > 150) ? 3 : ((slices % 3 == 0) ? 4 : 0));
            slices++;
        end

        // Zero processes: all_done only.
        do_start(0);

        // Reset while scanning after a proc_end.
        do_start(3);
        @(negedge clk);
        retire   = 1'b1;
        stall    = 1'b0;
        io_instr = 1'b0;
        proc_end = 1'b1;
        @(negedge clk);
        chk("busy_select", 32'(busy), 1);
        chk("cur_proc_select", 32'(cur_proc), 1);
        retire   = 1'b0;
        proc_end = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_rst_switch_req", 32'(switch_req), 0);
        chk("async_rst_next_pc", next_pc, 0);
        chk("async_rst_cur_proc", 32'(cur_proc), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_all_done", 32'(all_done), 0);
        @(negedge clk);
        reset     = 1'b0;
        m_running = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_switch", 32'(switch_req), 0);
            drive_garbage();
        end

        // Random campaigns.
        for (int t = 0; t < 12; t++) begin
            do_start(int'($urandom_range(0, 15)));
            slices = 0;
            while (m_running) begin
                int md;
                md = int'($urandom_range(0, 5));
                if (slices > 150) md = 3;
                case (md)
                    3:       run_slice(1);
                    4:       run_slice(2);
                    5:       run_slice(4);
                    6:       run_slice(3);
                    default: run_slice(0);
                endcase
                if (md == 3 && slices > 150) slices = slices;
                slices++;
            end
        end

        finish_tb();
    end

endmodule
